alu_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one fixed-point ALU (in_valid/busy/out_valid handshake, 16-bit Q6.10) among
//  NUM_REQ requesters. Accepts one request, issues it to the ALU, and captures the result.

---
 rtl/alu_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_rr_sched.sv | 128 ++++++++++++
 tb/tb_alu_rr_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared constants for the round-robin ALU scheduler:
// FSM state codes and ALU opcodes (also used by the bench).
package alu_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  localparam logic [3:0] ADD = 4'h0;
  localparam logic [3:0] SUB = 4'h1;
  localparam logic [3:0] MUL = 4'h2;
  localparam logic [3:0] ACC = 4'h3;
  localparam logic [3:0] CLR = 4'h4;
  localparam logic [3:0] SHL = 4'h5;
  localparam logic [3:0] SHR = 4'h6;
  localparam logic [3:0] ABS = 4'h7;
  localparam logic [3:0] NEG = 4'h8;
  localparam logic [3:0] RM4 = 4'h9;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// strictly after ptr, wrapping, as one-hot and index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int k;

  // Scan farthest offset first so the nearest one wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int o = NUM_REQ; o >= 1; o--) begin
      k = (int'(ptr) + o) % NUM_REQ;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = ID_W'(k);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU, one op in flight.
// Optional watchdog in S_WAIT: define ALU_SCHED_WDOG_EN.
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int INST_W      = 4,
  parameter int DATA_W      = 16,
  parameter int WDOG_CYCLES = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*INST_W-1:0] i_req_inst,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
  output logic                      o_alu_in_valid,
  output logic [INST_W-1:0]         o_alu_inst,
  output logic [DATA_W-1:0]         o_alu_a,
  output logic [DATA_W-1:0]         o_alu_b,
  input  logic                      i_alu_busy,
  input  logic                      i_alu_out_valid,
  input  logic [DATA_W-1:0]         i_alu_data,
  output logic                      o_rsp_valid,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_rsp_err,
  input  logic                      i_rsp_ready
);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     win;
  logic                any;
  logic                wdog_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (i_req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  assign o_req_ready    = (state == S_IDLE) ? gnt : '0;
  assign o_alu_in_valid = (state == S_ISSUE) && !i_alu_busy;
  assign o_rsp_valid    = (state == S_RESP);
  assign o_rsp_id       = id_q;

`ifdef ALU_SCHED_WDOG_EN
  logic [4:0] wdog_cnt;

  assign wdog_hit = (wdog_cnt == 5'(WDOG_CYCLES - 1));

  // Counter sits at zero outside S_WAIT, so it is clear on entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdog_cnt  <= '0;
      o_rsp_err <= 1'b0;
    end else begin
      if (state != S_WAIT)
        wdog_cnt <= '0;
      else if (!wdog_hit)
        wdog_cnt <= wdog_cnt + 5'd1;
      if (state == S_WAIT && !i_alu_out_valid && wdog_hit)
        o_rsp_err <= 1'b1;
      else if (state == S_RESP && i_rsp_ready)
        o_rsp_err <= 1'b0;
    end
  end
`else
  assign wdog_hit  = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      ptr        <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      o_alu_inst <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_rsp_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any) begin
            id_q       <= win;
            o_alu_inst <= i_req_inst[int'(win)*INST_W +: INST_W];
            o_alu_a    <= i_req_a[int'(win)*DATA_W +: DATA_W];
            o_alu_b    <= i_req_b[int'(win)*DATA_W +: DATA_W];
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!i_alu_busy)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_alu_out_valid) begin
            o_rsp_data <= i_alu_data;
            state      <= S_RESP;
          end else if (wdog_hit) begin
            o_rsp_data <= '0;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          // Fairness pointer advances on completion only.
          if (i_rsp_ready) begin
            ptr   <= id_q;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: ALU emulator, scoreboard model,
// and directed scenarios with literal expectations.
module tb_alu_rr_sched;
  import alu_sched_pkg::*;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int INW = 4;
  localparam int DW  = 16;
  localparam int WD  = 15;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*INW-1:0] req_inst = '0;
  logic [N*DW-1:0]  req_a = '0;
  logic [N*DW-1:0]  req_b = '0;
  logic             alu_in_valid;
  logic [INW-1:0]   alu_inst;
  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic             alu_busy;
  logic             alu_out_valid = 1'b0;
  logic [DW-1:0]    alu_data = '0;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic             rsp_ready = 1'b1;

  logic emu_busy = 1'b0;
  logic force_busy = 1'b0;
  logic hang = 1'b0;
  assign alu_busy = emu_busy | force_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inv_total = 0;
  int gl[$];

  alu_rr_sched #(
    .NUM_REQ(N), .ID_W(IW), .INST_W(INW),
    .DATA_W(DW), .WDOG_CYCLES(WD)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_inst      (req_inst),
    .i_req_a         (req_a),
    .i_req_b         (req_b),
    .o_alu_in_valid  (alu_in_valid),
    .o_alu_inst      (alu_inst),
    .o_alu_a         (alu_a),
    .o_alu_b         (alu_b),
    .i_alu_busy      (alu_busy),
    .i_alu_out_valid (alu_out_valid),
    .i_alu_data      (alu_data),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_id        (rsp_id),
    .o_rsp_data      (rsp_data),
    .o_rsp_err       (rsp_err),
    .i_rsp_ready     (rsp_ready)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int p);
    for (int o = 1; o <= N; o++)
      if (v[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] ref_fn(
    logic [INW-1:0] op, logic [DW-1:0] a,
    logic [DW-1:0] b, logic [DW-1:0] acc);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      ACC:     return acc + b;
      default: return a;
    endcase
  endfunction

  always @(posedge i_clk) cyc++;

  // ALU emulator: result two cycles after in_valid, busy between.
  logic [DW-1:0] emu_acc = '0;
  logic [DW-1:0] emu_res = '0;
  int emu_stage = 0;
  initial begin
    forever begin
      @(posedge i_clk); #1;
      alu_out_valid = 1'b0;
      if (emu_stage == 2) begin
        emu_stage = 1;
        emu_busy = 1'b1;
      end else if (emu_stage == 1) begin
        emu_stage = 0;
        emu_busy = 1'b0;
        alu_out_valid = 1'b1;
        alu_data = emu_res;
      end
      @(negedge i_clk);
      if (alu_in_valid && !hang) begin
        emu_res = ref_fn(alu_inst, alu_a, alu_b, emu_acc);
        if (alu_inst == ACC) emu_acc = emu_acc + alu_b;
        emu_stage = 2;
      end
    end
  end

  // Scoreboard: one op at a time, rr pointer moves on completion.
  bit             m_busy = 0;
  bit             m_issued = 0;
  bit             m_hang = 0;
  int             m_ptr = N - 1;
  int             m_id = 0;
  int             m_acc_cyc = 0;
  int             m_rsp_cyc = 0;
  logic [INW-1:0] m_inst = '0;
  logic [DW-1:0]  m_a = '0;
  logic [DW-1:0]  m_b = '0;
  logic [DW-1:0]  m_res = '0;
  logic [DW-1:0]  m_acc = '0;

  always @(negedge i_clk) begin : sb
    logic [N-1:0] er;
    int w;
    bit ev;
    if (!i_rst_n) begin
      chk("rst_outs", 32'(|{req_ready, alu_in_valid, alu_inst,
          alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err}), 0);
      m_busy = 0;
      m_ptr = N - 1;
    end else begin
      er = '0;
      w = -1;
      if (!m_busy) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) er[w] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      if (alu_in_valid) begin
        inv_total++;
        chk("issue_ok", {m_busy, m_issued, alu_busy,
            cyc > m_acc_cyc}, 4'b1001);
        chk("issue_inst", 32'(alu_inst), 32'(m_inst));
        chk("issue_a", 32'(alu_a), 32'(m_a));
        chk("issue_b", 32'(alu_b), 32'(m_b));
        if (!m_issued) begin
          m_issued = 1;
          m_rsp_cyc = cyc + (m_hang ? WD + 1 : 3);
        end
      end else if (m_busy && !m_issued && cyc > m_acc_cyc) begin
        chk("issue_stall", 32'(alu_busy), 1);
      end
      ev = m_busy && m_issued && cyc >= m_rsp_cyc;
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_data", 32'(rsp_data), 32'(m_res));
        chk("rsp_err", 32'(rsp_err), 32'(m_hang));
        if (rsp_ready) begin
          m_busy = 0;
          m_ptr = m_id;
        end
      end
      if (w >= 0) begin
        m_busy = 1;
        m_issued = 0;
        m_id = w;
        m_inst = req_inst[w*INW +: INW];
        m_a = req_a[w*DW +: DW];
        m_b = req_b[w*DW +: DW];
        m_acc_cyc = cyc;
        m_hang = hang;
        m_res = hang ? '0 : ref_fn(m_inst, m_a, m_b, m_acc);
        if (!hang && m_inst == ACC) m_acc = m_acc + m_b;
        gl.push_back(w);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [INW-1:0] op,
                         input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic v);
    req_inst[k*INW +: INW] = op;
    req_a[k*DW +: DW] = a;
    req_b[k*DW +: DW] = b;
    req_valid[k] = v;
  endtask

  task automatic accept(input int k, output int t);
    int n;
    n = 0;
    t = -1;
    while (n < 20) begin
      #1;
      if (req_ready[k]) begin
        t = cyc;
        break;
      end
      tick();
      n++;
    end
    chk("accept_timeout", 32'(t >= 0), 1);
    tick();
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(output int t);
    int n;
    n = 0;
    t = -1;
    while (n < 60) begin
      #1;
      if (rsp_valid) begin
        t = cyc;
        break;
      end
      tick();
      n++;
    end
    chk("rsp_timeout", 32'(t >= 0), 1);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick(3);
    i_rst_n = 1'b1;
    tick();
  endtask

  int t0, t1, inv0, n;
  int exp2[5] = '{0, 1, 2, 3, 0};

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_ready", 32'(req_ready), 0);
    i_rst_n = 1'b1;
    tick();

    // 1: single ADD from req0
    inv0 = inv_total;
    set_req(0, ADD, 16'h0400, 16'h0800, 1'b1);
    accept(0, t0);
    wait_rsp(t1);
    chk("t1_lat", 32'(t1 - t0), 4);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_data", 32'(rsp_data), 32'h0C00);
    tick(2);
    chk("t1_inv", 32'(inv_total - inv0), 1);

    // 2: all requesting, fresh pointer
    do_reset();
    gl.delete();
    for (int k = 0; k < N; k++)
      set_req(k, ADD, 16'(k * 16'h0100), 16'h0010, 1'b1);
    n = 0;
    while (gl.size() < 5 && n < 60) begin
      tick();
      n++;
    end
    req_valid = '0;
    tick(8);
    for (int i = 0; i < 5; i++)
      chk("t2_order", (i < gl.size()) ? gl[i] : -1, exp2[i]);

    // 3: response back-pressure
    rsp_ready = 1'b0;
    set_req(2, SUB, 16'h1000, 16'h0400, 1'b1);
    set_req(3, ADD, 16'h0001, 16'h0001, 1'b1);
    accept(2, t0);
    wait_rsp(t1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid", 32'(rsp_valid), 1);
      chk("t3_id", 32'(rsp_id), 2);
      chk("t3_data", 32'(rsp_data), 32'h0C00);
      chk("t3_ready", 32'(req_ready), 0);
      chk("t3_inv", 32'(alu_in_valid), 0);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid[3] = 1'b0;
    tick(3);

    // ALU busy stall delays issue
    set_req(1, ADD, 16'h0100, 16'h0200, 1'b1);
    accept(1, t0);
    force_busy = 1'b1;
    tick(3);
    force_busy = 1'b0;
    wait_rsp(t1);
    chk("stall_lat", 32'(t1 - t0), 7);
    chk("stall_data", 32'(rsp_data), 32'h0300);
    tick(2);

    // 4: accumulate through two requesters
    inv0 = inv_total;
    set_req(1, ACC, 16'h0000, 16'h0400, 1'b1);
    accept(1, t0);
    wait_rsp(t1);
    chk("t4_first", 32'(rsp_data), 32'h0400);
    tick();
    set_req(2, ACC, 16'h0000, 16'h0400, 1'b1);
    accept(2, t0);
    wait_rsp(t1);
    chk("t4_second", 32'(rsp_data), 32'h0800);
    chk("t4_id", 32'(rsp_id), 2);
    tick(2);
    chk("t4_inv", 32'(inv_total - inv0), 2);

    // 5: reset while waiting on the ALU
    set_req(0, ADD, 16'h0100, 16'h0100, 1'b1);
    accept(0, t0);
    tick();
    i_rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", 32'(|{req_ready, alu_in_valid, alu_inst,
        alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err}), 0);
    tick(3);
    i_rst_n = 1'b1;
    gl.delete();
    for (int k = 0; k < N; k++)
      set_req(k, ADD, 16'(k), 16'h0001, 1'b1);
    accept(0, t0);
    req_valid = '0;
    chk("t5_first", (gl.size() > 0) ? gl[0] : -1, 0);
    wait_rsp(t1);
    chk("t5_data", 32'(rsp_data), 32'h0001);
    tick(2);

`ifdef ALU_SCHED_WDOG_EN
    // 6: ALU never answers
    hang = 1'b1;
    set_req(0, ADD, 16'h0400, 16'h0400, 1'b1);
    accept(0, t0);
    wait_rsp(t1);
    chk("t6_lat", 32'(t1 - t0), 17);
    chk("t6_err", 32'(rsp_err), 1);
    chk("t6_data", 32'(rsp_data), 0);
    tick();
    hang = 1'b0;
    tick(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
